mac_dot_ctrl: RTL and testbench
===============================

// Module: mac_dot_ctrl
// PURPOSE
//  Sequencer for the 32x32->64 MAC datapath: runs one dot product per command.
//  Accepts a command carrying a vector length and clears the MAC.
//  Streams LEN operand pairs into the MAC, waits for the final accumulate,
//  and returns the 64-bit sum on a result handshake.
//  Sits between the operand-fetch logic and the MAC unit; the MAC is external to this block.
// PARAMETERS
//  DATA_W  32  operand width (A, B)
//  ACC_W   64  accumulator/result width
//  LEN_W   16  width of the vector-length field
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  cmd_valid  in   1       command offered
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_len    in   LEN_W   number of operand pairs (0 allowed)
//  in_valid   in   1       operand pair offered
//  in_ready   out  1       operand pair accepted when valid&ready
//  in_a       in   DATA_W  operand A
//  in_b       in   DATA_W  operand B
//  mac_clr    out  1       MAC clear strobe (acc<=0 next edge)
//  mac_en     out  1       MAC accumulate strobe (acc<=acc+a*b next edge)
//  mac_a      out  DATA_W  operand A to MAC
//  mac_b      out  DATA_W  operand B to MAC
//  mac_acc    in   ACC_W   registered MAC accumulator
//  res_valid  out  1       result available
//  res_ready  in   1       result consumed when valid&ready
//  res_data   out  ACC_W   dot-product result
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - MAC contract: clr has priority over en; arithmetic is unsigned, modulo 2^ACC_W;
//    1-cycle latency from strobe to mac_acc update.
//  - Reset (async): state=IDLE, count=0, res_data=0, and all outputs 0 except cmd_ready=1.
//  - States: IDLE, CLEAR, RUN, DRAIN, RESULT.
//  - IDLE: cmd_ready=1. On cmd accept: latch len, count<=0.
//    If len==0: res_data<=0 and go to RESULT. Otherwise go to CLEAR.
//  - CLEAR: mac_clr=1 for exactly 1 cycle, then go to RUN.
//  - RUN: in_ready=1. mac_en=in_valid&in_ready.
//    mac_a/mac_b = in_a/in_b, passed combinationally; both are 0 when mac_en=0.
//    Each accept does count++. The accept with count==len-1 goes to DRAIN.
//    in_valid low stalls without penalty.
//  - DRAIN: 1 cycle with no strobes; mac_acc now holds the final sum.
//    res_data<=mac_acc, then go to RESULT.
//  - RESULT: res_valid=1; res_data stays stable until res_ready.
//    On accept go to IDLE.
//    A new command cannot be accepted in the same cycle as the result accept.
//  - cmd_ready=0 and in_ready=0 outside IDLE and RUN respectively.
//    Inputs arriving outside those windows are ignored.
//  - mac_clr and mac_en are never high in the same cycle.
//  - Latency for len=N with no stalls: cmd accept -> res_valid is N+3 cycles.
//  - Latency for len=0: res_valid one cycle after cmd accept.
//  - len=2^LEN_W-1 is legal; count must not wrap before termination.
//  - Reset mid-operation: return immediately to IDLE; any partial sum is discarded.
//    The next command re-clears the MAC.
// TESTING
//  1. len=4, A={1,2,3,4}, B=2 each, no stalls -> res_data=20, res_valid 7 cycles after cmd accept.
//  2. len=0 -> no mac_clr/mac_en pulses, res_data=0, res_valid the cycle after accept.
//  3. len=3, A={5,6,7}, B={1,1,1}, in_valid low 2 cycles between beats -> res_data=18,
//     exactly 3 mac_en pulses.
//  4. len=1, A=3, B=3, res_ready low 5 cycles -> res_valid and res_data=9 held;
//     cmd_ready=0 and busy=1 throughout.
//  5. len=2, A=B=0xFFFFFFFF -> res_data=0xFFFFFFFC00000002 (modulo wrap).
//  6. Assert reset during RUN after 2 of 4 beats -> IDLE, outputs at reset values.
//     Then len=1, A=4, B=5 -> mac_clr pulse then res_data=20.

Source files
------------

// File: rtl/mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl
//   Sequencer for an external 32x32->64 MAC: runs one dot product per command.
//   A command carries the vector length. The block clears the MAC, streams
//   that many operand pairs into it, waits one cycle for the last accumulate
//   to land, and then returns the sum on a result handshake.
//
// Ports
//   clk, reset            clock / asynchronous active-high reset
//   cmd_valid/ready/len   command handshake and vector length (0 allowed)
//   in_valid/ready/a/b    operand-pair stream
//   mac_clr, mac_en       MAC strobes (never high together)
//   mac_a, mac_b          operands to MAC (zero when mac_en is low)
//   mac_acc               registered MAC accumulator (1-cycle latency)
//   res_valid/ready/data  result handshake
//   busy                  high whenever not idle
// ---------------------------------------------------------------------------
module mac_dot_ctrl #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;

  // Handshake windows and strobes are pure decodes of the state.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    in_ready  = (state_q == S_RUN);
    mac_clr   = (state_q == S_CLEAR);
    mac_en    = in_ready & in_valid;
    mac_a     = mac_en ? in_a : '0;
    mac_b     = mac_en ? in_b : '0;
    res_valid = (state_q == S_RESULT);
    res_data  = res_data_q;
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    res_data_d = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          count_d = '0;
          if (cmd_len == '0) begin
            // Empty vector: skip the MAC entirely and report zero.
            res_data_d = '0;
            state_d    = S_RESULT;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (mac_en) begin
          // len_q >= 1 here, so len_q-1 never underflows and count_q
          // stays below len_q; no wrap even at the maximum length.
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last accumulate has landed in mac_acc by this cycle.
        res_data_d = mac_acc;
        state_d    = S_RESULT;
      end
      S_RESULT: begin
        // Returning to IDLE first keeps result accept and the next
        // command accept in separate cycles.
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      res_data_q <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
module tb_mac_dot_ctrl;
  localparam int LW = 6;  // small length field so the maximum length is cheap to run

  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        mac_clr, mac_en;
  logic [31:0] mac_a, mac_b;
  logic [63:0] mac_acc = 64'hDEAD_BEEF_0BAD_F00D;
  logic        res_valid, res_ready = 0;
  logic [63:0] res_data;
  logic        busy;

  mac_dot_ctrl #(.DATA_W(32), .ACC_W(64), .LEN_W(LW)) dut (
    .clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External MAC behaviour: clear wins, unsigned wrap, 1-cycle latency.
  always @(posedge clk) begin
    if (mac_clr)     mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + 64'(mac_a) * 64'(mac_b);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0, tot_cnt = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h @cyc %0d", nm, got, exp, cyc);
  endtask

  typedef struct {
    logic [63:0] sum;
    int          len;
    int          exp_cyc;  // -1: latency not checked
  } exp_t;
  exp_t sb[$];

  // Monitor: strobe checks every cycle, scoreboard pop on each result accept.
  int clr_cnt = 0, en_cnt = 0, rv_cyc = 0;
  bit prev_rv = 0;
  always @(negedge clk) begin
    if (rst) begin
      clr_cnt = 0; en_cnt = 0; prev_rv = 0;
    end else begin
      exp_t e;
      chk("clr_en_excl", 64'(mac_clr & mac_en), 64'd0);
      chk("mac_a", 64'(mac_a), mac_en ? 64'(in_a) : 64'd0);
      chk("mac_b", 64'(mac_b), mac_en ? 64'(in_b) : 64'd0);
      if (mac_clr) clr_cnt++;
      if (mac_en)  en_cnt++;
      if (res_valid && !prev_rv) rv_cyc = cyc;
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        chk("cmd_ready_at_res_accept", 64'(cmd_ready), 64'd0);
        if (sb.size() == 0) chk("sb_nonempty", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          chk("res_data", res_data, e.sum);
          chk("clr_pulses", 64'(clr_cnt), (e.len == 0) ? 64'd0 : 64'd1);
          chk("en_pulses", 64'(en_cnt), 64'(e.len));
          if (e.exp_cyc >= 0) chk("latency", 64'(rv_cyc), 64'(e.exp_cyc));
        end
        clr_cnt = 0; en_cnt = 0;
      end
    end
  end

  logic [31:0] av[64], bv[64];

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_strobes"},   64'({mac_clr, mac_en}), 64'd0);
    chk({tag, "_mac_ops"},   {mac_a, mac_b}, 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_data"},  res_data, 64'd0);
    chk({tag, "_busy"},      64'(busy), 64'd0);
  endtask

  // gap: idle cycles before each beat after the first (-1 = random 0..2).
  // hold: cycles res_ready stays low once res_valid rises.
  // abort_at >= 0: assert reset after that many beats instead of finishing.
  task automatic run_cmd(input int len, input int gap, input int hold, input int abort_at);
    logic [63:0] s = '0;
    int n, gp;
    exp_t e;
    for (int i = 0; i < len; i++) s += 64'(av[i]) * 64'(bv[i]);
    cmd_len = LW'(len); cmd_valid = 1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin chk("cmd_timeout", 64'd0, 64'd1); cmd_valid = 0; return; end
    if (abort_at < 0) begin
      e.sum = s; e.len = len;
      e.exp_cyc = (gap == 0) ? cyc + ((len == 0) ? 1 : len + 3) : -1;
      sb.push_back(e);
    end
    @(posedge clk); #1 cmd_valid = 0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        rst = 1; #1;
        chk_reset_outputs("abort");
        @(posedge clk); #1 rst = 0;
        chk_reset_outputs("post_abort");
        return;
      end
      gp = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i > 0 && gp > 0) begin repeat (gp) @(posedge clk); #1; end
      in_valid = 1; in_a = av[i]; in_b = bv[i];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin chk("in_timeout", 64'd0, 64'd1); in_valid = 0; return; end
      @(posedge clk); #1 in_valid = 0; in_a = $urandom; in_b = $urandom;
    end
    if (hold == 0) res_ready = 1;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    if (!res_valid) begin chk("res_timeout", 64'd0, 64'd1); res_ready = 0; return; end
    for (int h = 0; h < hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", res_data, s);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    if (hold > 0) begin @(posedge clk); #1 res_ready = 1; end
    @(posedge clk); #1 res_ready = 0;
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 0;
    chk_reset_outputs("idle");

    // 1: len 4, A=1..4, B=2, no stalls -> 20, latency 7
    for (int i = 0; i < 4; i++) begin av[i] = 32'(i + 1); bv[i] = 32'd2; end
    run_cmd(4, 0, 0, -1);
    // 2: len 0 -> 0, no strobes, latency 1
    run_cmd(0, 0, 1, -1);
    // 3: len 3 with 2-cycle gaps -> 18
    av[0] = 5; av[1] = 6; av[2] = 7; bv[0] = 1; bv[1] = 1; bv[2] = 1;
    run_cmd(3, 2, 0, -1);
    // 4: len 1, 3*3, res_ready low 5 cycles
    av[0] = 3; bv[0] = 3;
    run_cmd(1, 0, 5, -1);
    // 5: modulo wrap
    av[0] = '1; av[1] = '1; bv[0] = '1; bv[1] = '1;
    run_cmd(2, 0, 0, -1);
    // 6: reset after 2 of 4 beats, then 4*5
    for (int i = 0; i < 4; i++) begin av[i] = $urandom; bv[i] = $urandom; end
    run_cmd(4, 0, 0, 2);
    av[0] = 4; bv[0] = 5;
    run_cmd(1, 0, 1, -1);
    // maximum length for the field
    for (int i = 0; i < 63; i++) begin av[i] = $urandom; bv[i] = $urandom; end
    run_cmd(63, 0, 1, -1);
    // randomized commands
    for (int t = 0; t < 25; t++) begin
      int len;
      len = int'($urandom_range(0, 8));
      for (int i = 0; i < len; i++) begin av[i] = $urandom; bv[i] = $urandom; end
      run_cmd(len, (t % 2 == 0) ? 0 : -1, int'($urandom_range(0, 3)), -1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
